parking_gate_arbiter: RTL

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/park_pkg.sv | 23 ++
 rtl/parking_gate_arbiter_gate_timer.sv | 33 +++
 rtl/parking_gate_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/park_pkg.sv
// Shared definitions for the parking gate arbiter: FSM state encoding,
// default timing/capacity constants and the timer width helper.
package park_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OPEN_IN,
      OPEN_OUT,
      CLOSING
   } gate_state_t;

   localparam int unsigned DEF_CAPACITY     = 8;
   localparam int unsigned DEF_OPEN_TIMEOUT = 20;
   localparam int unsigned DEF_CLOSE_CYCLES = 4;

   // Width able to hold the larger of the two terminal counts (at least 1 bit).
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/parking_gate_arbiter_gate_timer.sv
// Up-counter from zero; load arms a new terminal value and restarts the count,
// tc flags count == terminal and the count holds there.
module gate_timer
   import park_pkg::*;
#(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] count,
   output logic         tc
);

   logic [W-1:0] term;

   assign tc = (count == term);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
         term  <= '0;
      end else if (load) begin
         count <= '0;
         term  <= load_value;
      end else if (!tc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/parking_gate_arbiter.sv
// Parking barrier arbiter: grants entry/exit requests round-robin, times the
// open window and the closing guard interval, and tracks lot occupancy.
module parking_gate_arbiter
   import park_pkg::*;
#(
   parameter int unsigned CAPACITY     = DEF_CAPACITY,
   parameter int unsigned OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
   parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_req,
   input  logic       exit_req,
   input  logic       pass_sensor,
   output logic       grant_in,
   output logic       grant_out,
   output logic       gate_open,
   output logic       dir_in,
   output logic [7:0] occupancy,
   output logic       full,
   output logic       empty,
   output logic       timeout_err
);

   localparam int unsigned TW = timer_width(OPEN_TIMEOUT, CLOSE_CYCLES);
   localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
   localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
   localparam logic [7:0]    CAP        = 8'(CAPACITY);

   gate_state_t    state, state_n;
   logic           last_in, last_in_n;
   logic           dir_in_n;
   logic           elig_in, elig_out;
   logic           occ_inc, occ_dec, to_fire;
   logic           t_clear, t_load;
   logic [TW-1:0]  t_value;
   logic [TW-1:0]  t_count;
   logic           t_tc;

   gate_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .clear      (t_clear),
      .load       (t_load),
      .load_value (t_value),
      .count      (t_count),
      .tc         (t_tc)
   );

   assign full      = (occupancy == CAP);
   assign empty     = (occupancy == '0);
   assign elig_in   = entry_req && !full;
   assign elig_out  = exit_req && !empty;
   assign gate_open = (state == OPEN_IN) || (state == OPEN_OUT);
   // The timer is reloaded on every grant, so count zero marks the first open cycle.
   assign grant_in  = (state == OPEN_IN)  && (t_count == '0);
   assign grant_out = (state == OPEN_OUT) && (t_count == '0);

   always_comb begin
      state_n   = state;
      last_in_n = last_in;
      dir_in_n  = dir_in;
      occ_inc   = 1'b0;
      occ_dec   = 1'b0;
      to_fire   = 1'b0;
      t_clear   = 1'b0;
      t_load    = 1'b0;
      t_value   = '0;
      unique case (state)
         IDLE: begin
            if (elig_in && (!elig_out || !last_in)) begin
               state_n  = OPEN_IN;
               dir_in_n = 1'b1;
               t_load   = 1'b1;
               t_value  = OPEN_LAST;
            end else if (elig_out) begin
               state_n  = OPEN_OUT;
               dir_in_n = 1'b0;
               t_load   = 1'b1;
               t_value  = OPEN_LAST;
            end
         end
         OPEN_IN, OPEN_OUT: begin
            if (pass_sensor || t_tc) begin
               state_n   = CLOSING;
               last_in_n = (state == OPEN_IN);
               t_load    = 1'b1;
               t_value   = CLOSE_LAST;
               if (pass_sensor) begin
                  occ_inc = (state == OPEN_IN);
                  occ_dec = (state == OPEN_OUT);
               end else begin
                  to_fire = 1'b1;
               end
            end
         end
         CLOSING: begin
            if (t_tc) begin
               state_n = IDLE;
               t_clear = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_in     <= 1'b0;
         dir_in      <= 1'b0;
         occupancy   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         last_in     <= last_in_n;
         dir_in      <= dir_in_n;
         timeout_err <= to_fire;
         if (occ_inc)
            occupancy <= occupancy + 8'd1;
         else if (occ_dec)
            occupancy <= occupancy - 8'd1;
      end
   end

endmodule
